// File: rtl/spi_rx_deser_if.sv
// Bus bundle for the SPI receive deserializer.
//   sclk/cs/mosi : serial stream from the transmitter (cs active-low)
//   dout/valid   : received word and its valid flag
//   ready        : consumer accepts dout when valid && ready
//   frame_err    : one-cycle pulse, frame ended with the wrong bit count
//   overrun      : one-cycle pulse, good frame dropped while valid was held
// The slave modport is the deserializer; the master modport is the
// transmitter plus consumer side.
interface spi_rx_deser_if #(
  parameter int DATA_W = 12
);
  logic              sclk;
  logic              cs;
  logic              mosi;
  logic [DATA_W-1:0] dout;
  logic              valid;
  logic              ready;
  logic              frame_err;
  logic              overrun;

  modport slave  (input  sclk, cs, mosi, ready,
                  output dout, valid, frame_err, overrun);
  modport master (output sclk, cs, mosi, ready,
                  input  dout, valid, frame_err, overrun);
endinterface

// File: rtl/spi_rx_deser.sv
// SPI receive deserializer. Oversamples sclk/cs/mosi in the clk domain,
// rebuilds LSB-first frames of DATA_W bits and holds each good word on a
// valid/ready output. Wrong-length frames pulse frame_err; a good frame
// arriving while the previous word is still held pulses overrun.
// Ports:
//   clk : system clock, posedge
//   rst : asynchronous active-high reset
//   bus : spi_rx_deser_if slave modport (serial in, word/handshake out)
module spi_rx_deser #(
  parameter int DATA_W      = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           rst,
  spi_rx_deser_if.slave  bus
);

  localparam int CW     = $clog2(DATA_W + 2);
  // Cycles after reset before cs edges are trusted: the cs chain resets
  // high, so if cs is already low the chain would fake a falling edge
  // while it fills. Waiting until the delay flop has caught up hides it.
  localparam int SETTLE = SYNC_STAGES + 1;
  localparam int SW     = $clog2(SETTLE + 1);

  typedef enum logic [1:0] {IDLE, SKIP, SHIFT, DONE} state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sclk_dly_q, cs_dly_q;
  logic [SW-1:0]          settle_q;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] sr_q, sr_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              valid_q, valid_d;
  logic              ferr_q, ferr_d;
  logic              ovr_q, ovr_d;

  logic sclk_s, cs_s, mosi_s;
  logic sclk_fall, cs_fall, cs_rise, armed;

  // Input synchronizers plus one delay flop each for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_dly_q  <= 1'b0;
      cs_dly_q    <= 1'b1;
      settle_q    <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0],   bus.cs};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
      sclk_dly_q  <= sclk_s;
      cs_dly_q    <= cs_s;
      if (!armed) settle_q <= settle_q + 1'b1;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign armed     = (settle_q == SW'(SETTLE));
  assign sclk_fall = sclk_dly_q & ~sclk_s;
  assign cs_fall   = cs_dly_q & ~cs_s & armed;
  assign cs_rise   = ~cs_dly_q & cs_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    dout_d  = dout_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;

    // Consumer handshake; a load in DONE below overrides the clear.
    if (valid_q && bus.ready) valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          cnt_d   = '0;
          state_d = SKIP;
        end
      end
      SKIP: begin
        // First falling edge after cs carries stale data.
        if (cs_rise) begin
          ferr_d  = 1'b1;
          state_d = IDLE;
        end else if (sclk_fall) begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Sample is taken before acting on a coincident cs_rise.
        if (sclk_fall) begin
          if (cnt_q < CW'(DATA_W)) begin
            sr_d  = {mosi_s, sr_q[DATA_W-1:1]};
            cnt_d = cnt_q + 1'b1;
          end else begin
            cnt_d = CW'(DATA_W + 1);  // marks overlength
          end
        end
        if (cs_rise) state_d = DONE;
      end
      DONE: begin
        if (cnt_q == CW'(DATA_W)) begin
          if (!valid_q || bus.ready) begin
            dout_d  = sr_q;
            valid_d = 1'b1;
          end else begin
            ovr_d = 1'b1;
          end
        end else begin
          ferr_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.dout      = dout_q;
  assign bus.valid     = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.overrun   = ovr_q;

endmodule

// File: tb/tb_spi_rx_deser.sv
module tb_spi_rx_deser;
  localparam int DATA_W = 12;
  localparam int SYNC   = 2;
  localparam int HALF   = 11;  // sclk half-period in clk cycles (clk/22)

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  spi_rx_deser_if #(.DATA_W(DATA_W)) bus_if ();

  spi_rx_deser #(.DATA_W(DATA_W), .SYNC_STAGES(SYNC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int checks   = 0;
  int failures = 0;
  int n_ferr   = 0;
  int n_ovr    = 0;
  bit cmp_on   = 1'b0;

  // Frame-level model: each completed frame resolves SYNC+2 clk edges
  // after cs is raised (synchronizer, cs_rise detect, DONE).
  int          cyc    = 0;
  int          ev_due = -1;
  logic        ev_good;
  logic [11:0] ev_data;

  logic [11:0] m_dout;
  logic        m_valid, m_ferr, m_ovr;
  logic        t_ld, t_free;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_dout  <= '0;
      m_valid <= 1'b0;
      m_ferr  <= 1'b0;
      m_ovr   <= 1'b0;
    end else begin
      t_ld   = 1'b0;
      t_free = !m_valid || bus_if.ready;
      m_ferr <= 1'b0;
      m_ovr  <= 1'b0;
      if (cyc + 1 == ev_due) begin
        if (!ev_good)    m_ferr <= 1'b1;
        else if (t_free) t_ld = 1'b1;
        else             m_ovr <= 1'b1;
      end
      if (t_ld) begin
        m_dout  <= ev_data;
        m_valid <= 1'b1;
      end else if (m_valid && bus_if.ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  // cs falls on an sclk rise; stale fall; then nbits bits driven on
  // rises and sampled on falls. Ends after the last sampling fall.
  task automatic send_bits(input logic [11:0] d, input int nbits, input int rst_at);
    hold(1);
    bus_if.sclk = 1'b1; bus_if.cs = 1'b0;
    hold(HALF);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        rst = 1'b1;
        hold(1);
        chk("rst_dout",  32'(bus_if.dout),      32'h0);
        chk("rst_valid", 32'(bus_if.valid),     32'h0);
        chk("rst_ferr",  32'(bus_if.frame_err), 32'h0);
        chk("rst_ovr",   32'(bus_if.overrun),   32'h0);
        rst = 1'b0;
      end
      bus_if.sclk = 1'b0;
      hold(HALF);
      bus_if.sclk = 1'b1;
      bus_if.mosi = (i < 12) ? d[i] : 1'b0;
      hold(HALF);
    end
    bus_if.sclk = 1'b0;
    hold(HALF);
  endtask

  task automatic cs_up(input logic [11:0] d, input int nbits, input bit track);
    bus_if.sclk = 1'b1;
    bus_if.cs   = 1'b1;
    ev_data = d;
    ev_good = (nbits == DATA_W);
    if (track) ev_due = cyc + SYNC + 2;
  endtask

  task automatic frame(input logic [11:0] d, input int nbits);
    send_bits(d, nbits, -1);
    cs_up(d, nbits, 1'b1);
    hold(HALF);
    bus_if.sclk = 1'b0;
    hold(HALF);
  endtask

  initial begin
    int f0, o0;
    bus_if.sclk = 1'b0; bus_if.cs = 1'b1; bus_if.mosi = 1'b0; bus_if.ready = 1'b0;

    fork
      forever begin
        @(negedge clk);
        if (cmp_on) begin
          chk("cyc_dout",  32'(bus_if.dout),      32'(m_dout));
          chk("cyc_valid", 32'(bus_if.valid),     32'(m_valid));
          chk("cyc_ferr",  32'(bus_if.frame_err), 32'(m_ferr));
          chk("cyc_ovr",   32'(bus_if.overrun),   32'(m_ovr));
          if (bus_if.frame_err) n_ferr++;
          if (bus_if.overrun)   n_ovr++;
        end
      end
    join_none

    #1 rst = 1'b1;
    hold(3);
    chk("init_dout",  32'(bus_if.dout),  32'h0);
    chk("init_valid", 32'(bus_if.valid), 32'h0);
    cmp_on = 1'b1;
    rst = 1'b0;
    hold(10);

    // 1: A5C with ready=1, latency and single valid cycle
    bus_if.ready = 1'b1;
    f0 = n_ferr; o0 = n_ovr;
    send_bits(12'hA5C, 12, -1);
    cs_up(12'hA5C, 12, 1'b1);
    hold(3);
    chk("t1_pre_valid", 32'(bus_if.valid), 32'h0);
    hold(1);
    chk("t1_valid", 32'(bus_if.valid), 32'h1);
    chk("t1_dout",  32'(bus_if.dout),  32'hA5C);
    hold(1);
    chk("t1_drop", 32'(bus_if.valid), 32'h0);
    hold(HALF - 5);
    bus_if.sclk = 1'b0;
    hold(HALF);
    chk("t1_ferr_cnt", 32'(n_ferr - f0), 32'h0);
    chk("t1_ovr_cnt",  32'(n_ovr - o0),  32'h0);

    // 2: back-to-back with ready=0 -> overrun on the second
    bus_if.ready = 1'b0;
    o0 = n_ovr;
    frame(12'h001, 12);
    hold(5);
    frame(12'hFFF, 12);
    hold(5);
    chk("t2_dout",    32'(bus_if.dout),  32'h001);
    chk("t2_valid",   32'(bus_if.valid), 32'h1);
    chk("t2_ovr_cnt", 32'(n_ovr - o0),   32'h1);
    bus_if.ready = 1'b1;
    hold(1);
    chk("t2_drop",   32'(bus_if.valid), 32'h0);
    chk("t2_dout_k", 32'(bus_if.dout),  32'h001);

    // 3: short frame, then good 3C3
    f0 = n_ferr;
    frame(12'h055, 7);
    hold(5);
    chk("t3_ferr_cnt", 32'(n_ferr - f0), 32'h1);
    chk("t3_dout",     32'(bus_if.dout), 32'h001);
    frame(12'h3C3, 12);
    hold(5);
    chk("t3_dout2", 32'(bus_if.dout), 32'h3C3);

    // 4: overlong frame (14 sampling edges)
    f0 = n_ferr;
    frame(12'hABC, 14);
    hold(5);
    chk("t4_ferr_cnt", 32'(n_ferr - f0), 32'h1);
    chk("t4_dout",     32'(bus_if.dout), 32'h3C3);

    // 5: reset mid-frame; remainder ignored silently
    f0 = n_ferr;
    send_bits(12'h555, 12, 6);
    cs_up(12'h555, 12, 1'b0);
    hold(HALF);
    bus_if.sclk = 1'b0;
    hold(HALF + 5);
    chk("t5_ferr_cnt", 32'(n_ferr - f0), 32'h0);
    chk("t5_dout0",    32'(bus_if.dout), 32'h0);
    frame(12'h2AA, 12);
    hold(5);
    chk("t5_dout", 32'(bus_if.dout), 32'h2AA);

    // 6: load coincides with valid&&ready
    bus_if.ready = 1'b0;
    frame(12'h111, 12);
    hold(5);
    chk("t6_first", 32'(bus_if.dout), 32'h111);
    o0 = n_ovr;
    send_bits(12'h0F0, 12, -1);
    cs_up(12'h0F0, 12, 1'b1);
    hold(3);
    bus_if.ready = 1'b1;
    hold(1);
    bus_if.ready = 1'b0;
    chk("t6_valid", 32'(bus_if.valid), 32'h1);
    chk("t6_dout",  32'(bus_if.dout),  32'h0F0);
    hold(HALF - 4);
    bus_if.sclk = 1'b0;
    hold(HALF);
    chk("t6_hold",    32'(bus_if.valid), 32'h1);
    chk("t6_ovr_cnt", 32'(n_ovr - o0),   32'h0);
    bus_if.ready = 1'b1;
    hold(2);
    chk("t6_drop", 32'(bus_if.valid), 32'h0);

    cmp_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
